dcache_port_arbiter: RTL
========================

Name: dcache_port_arbiter

Overview:
- Shares one data-cache request port (XLEN=32, Sv32 core) between three requesters: PTW, load unit and store/AMO unit.
- Round-robin arbitration with a lock for atomic sequences.
- Keeps an in-order FIFO of granted port indices so each cache response is routed back to the requester that issued it.
- Sits between the LSU/PTW and the data cache.

Parameters:
- NR_PORTS, 3, number of requesters (index 0=PTW, 1=load, 2=store).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width (equals XLEN).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; power of two, ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NR_PORTS  per-port request valid.
- req_ready_o  out  NR_PORTS  per-port request accepted this cycle.
- req_addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address.
- req_we_i  in  NR_PORTS  per-port write enable.
- req_wdata_i  in  NR_PORTS*DATA_WIDTH  per-port write data.
- req_be_i  in  NR_PORTS*DATA_WIDTH/8  per-port byte enables.
- req_lock_i  in  NR_PORTS  keep the grant on this port after this request.
- rsp_valid_o  out  NR_PORTS  per-port response strobe.
- rsp_rdata_o  out  DATA_WIDTH  response data, broadcast to all ports.
- mem_req_valid_o  out  1  cache request valid.
- mem_req_ready_i  in  1  cache accepts request.
- mem_addr_o / mem_we_o / mem_wdata_o / mem_be_o  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  muxed payload.
- mem_rsp_valid_i  in  1  cache response, returned in request order, one per request including writes.
- mem_rdata_i  in  DATA_WIDTH  response data.

Behaviour:
- State: rr_ptr (port index), hold_q + hold_idx, lock_q + lock_idx, index FIFO with count.
- Reset: rr_ptr=0, hold_q=0, lock_q=0, FIFO empty.
  - With all req_valid_i low, every valid/ready output is 0.
  - Payload outputs are don't-care but driven from port 0.
- Grant selection, combinational, in priority order:
  - hold_q=1 → hold_idx.
  - else lock_q=1 → lock_idx, granted only if that port is requesting; other ports are never granted while locked.
  - else the first requesting port at or after rr_ptr, with modular wrap.
- mem_req_valid_o = grant exists AND count<MAX_OUTSTANDING. Accept is gated on not-full even if a pop happens the same cycle.
- Payload is muxed from the granted port.
- Handshake: accept = mem_req_valid_o & mem_req_ready_i; req_ready_o[g] = accept.
  - mem_req_valid_o is never combinationally dependent on mem_req_ready_i.
- Stability: if mem_req_valid_o=1 and mem_req_ready_i=0, set hold_q and hold_idx=g; clear hold_q on accept.
  - The payload must stay stable until accept. Requesters must hold valid and payload until ready.
- On accept:
  - Push g into the FIFO.
  - rr_ptr <= (g+1) mod NR_PORTS.
  - If req_lock_i[g]=1: lock_q<=1, lock_idx<=g. Else lock_q<=0.
- Response:
  - mem_rsp_valid_i pops the FIFO head h.
  - rsp_valid_o[h]=1 in the same cycle (zero latency); rsp_rdata_o=mem_rdata_i.
  - Other bits of rsp_valid_o are 0.
- Simultaneous push and pop: count unchanged; FIFO ordering is preserved.
- mem_rsp_valid_i while the FIFO is empty: ignored (no rsp_valid_o); simulation assertion fires.
- Reset mid-operation: all state cleared immediately. Outstanding responses are lost; the cache is reset in the same domain.
- Counters wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING+1).

Decomposition:
- Package dcache_arb_pkg holds:
  - Port index constants PORT_PTW=0, PORT_LOAD=1, PORT_STORE=2.
  - localparam IDX_W = clog2(NR_PORTS).
  - Request struct typedef {addr, we, wdata, be, lock}.
- Sub-module dcache_arb_idx_fifo: depth MAX_OUTSTANDING, width IDX_W, push/pop/full/empty, fall-through read of the head.

Test Plan:
- Ports 0,1,2 all valid continuously, ready=1, response after each accept → grant order 0,1,2,0,1,2; responses route rsp_valid_o=001,010,100 in sequence.
- Port 1 valid, ready=0 for 3 cycles while port 0 asserts in cycle 2 → mem_addr_o stays at port 1 address; port 1 accepted in cycle 4, then port 0.
- Port 2 issues lock=1 then lock=0 while port 0 requests throughout → two back-to-back port-2 accepts, then port 0 granted.
- MAX_OUTSTANDING=2: two accepts with no responses, third request pending → mem_req_valid_o=0 until the first mem_rsp_valid_i, then valid the next cycle.
- Push and pop in the same cycle with count=1 → count stays 1; the popped index is routed correctly.
- Assert rst_ni=0 with count=2 and lock_q=1 → after release, port 0 (rr_ptr=0) wins a 0,1 contention; a stray mem_rsp_valid_i produces no rsp_valid_o.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - port indices, default widths and request type for the dcache port arbiter
package dcache_arb_pkg;

  localparam int ARB_NR_PORTS        = 3;
  localparam int ARB_ADDR_W          = 32;
  localparam int ARB_DATA_W          = 32;
  localparam int ARB_MAX_OUTSTANDING = 2;
  localparam int IDX_W               = $clog2(ARB_NR_PORTS);

  localparam logic [IDX_W-1:0] PORT_PTW   = IDX_W'(0);
  localparam logic [IDX_W-1:0] PORT_LOAD  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PORT_STORE = IDX_W'(2);

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   addr;
    logic                    we;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] be;
    logic                    lock;
  } dcache_req_t;

endpackage

// File: rtl/dcache_arb_idx_fifo.sv
// rtl/dcache_arb_idx_fifo.sv - in-order FIFO of granted port indices with fall-through head
module dcache_arb_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem_q[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin arbiter with atomic lock sharing one dcache port among PTW, load and store
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int NR_PORTS        = ARB_NR_PORTS,
  parameter int ADDR_WIDTH      = ARB_ADDR_W,
  parameter int DATA_WIDTH      = ARB_DATA_W,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NR_PORTS-1:0]            req_valid_i,
  output logic [NR_PORTS-1:0]            req_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NR_PORTS-1:0]            req_we_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] req_be_i,
  input  logic [NR_PORTS-1:0]            req_lock_i,
  output logic [NR_PORTS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic                           mem_we_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        mem_be_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  dcache_req_t      reqs [NR_PORTS];
  dcache_req_t      sel;
  logic [IDX_W-1:0] rr_ptr;
  logic             hold_q;
  logic [IDX_W-1:0] hold_idx;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;
  logic             rsp_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  int unsigned      cand;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_unpack
    assign reqs[p] = {req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH], req_we_i[p],
                      req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH], req_be_i[p*BE_W +: BE_W],
                      req_lock_i[p]};
  end

  // A stalled grant is pinned first so the payload cannot change before accept.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = PORT_PTW;
    cand        = 0;
    if (hold_q) begin
      grant_valid = 1'b1;
      grant_idx   = hold_idx;
    end else if (lock_q) begin
      grant_valid = req_valid_i[lock_idx];
      grant_idx   = lock_idx;
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        cand = (int'(rr_ptr) + i) % NR_PORTS;
        if (!grant_valid && req_valid_i[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
  end

  assign sel             = reqs[grant_idx];
  assign mem_addr_o      = sel.addr;
  assign mem_we_o        = sel.we;
  assign mem_wdata_o     = sel.wdata;
  assign mem_be_o        = sel.be;
  assign mem_req_valid_o = grant_valid & ~fifo_full;
  assign accept          = mem_req_valid_o & mem_req_ready_i;
  assign rsp_pop         = mem_rsp_valid_i & ~fifo_empty;
  assign rsp_rdata_o     = mem_rdata_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_pop) begin
      rsp_valid_o[fifo_head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= PORT_PTW;
      hold_q   <= 1'b0;
      hold_idx <= PORT_PTW;
      lock_q   <= 1'b0;
      lock_idx <= PORT_PTW;
    end else if (accept) begin
      hold_q   <= 1'b0;
      rr_ptr   <= (grant_idx == IDX_W'(NR_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      lock_q   <= sel.lock;
      lock_idx <= grant_idx;
    end else if (mem_req_valid_o) begin
      hold_q   <= 1'b1;
      hold_idx <= grant_idx;
    end
  end

  dcache_arb_idx_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(IDX_W)
  ) u_idx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (accept),
    .data_i (grant_idx),
    .pop_i  (rsp_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // A response with nothing outstanding is dropped; flag it in simulation.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rsp_valid_i && fifo_empty))
        else $warning("dcache response with no outstanding request dropped");
    end
  end

endmodule
